// File: rtl/ropuf_pkg.sv
// Shared definitions for the ring-oscillator PUF response sequencer.
// Holds the state encoding, the window-count landmarks used by the
// controller, and the RO counter width seen by the comparator.
package ropuf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_HOLD,
    S_NEXT,
    S_DONE
  } state_t;

  // Window count landmarks: RUN ends at RUN_END, the comparator window is
  // WIN_LO..WIN_HI and the comparator bit is taken at SAMPLE_AT.
  localparam logic [7:0] RUN_END   = 8'd244;
  localparam logic [7:0] WIN_LO    = 8'd245;
  localparam logic [7:0] SAMPLE_AT = 8'd248;
  localparam logic [7:0] WIN_HI    = 8'd250;

  // Width of each RO up/down counter behind the comparator.
  localparam int CNT_W = 16;

endpackage

// File: rtl/ropuf_controller_if.sv
// Handshake and datapath bundle between the PUF sequencer and its
// surroundings (key path, RO pair mux, counters and comparator).
//   master : drives start, abort, cmp_bit; observes everything else
//   slave  : the sequencer; drives pair_sel, ro_en, cnt_clr, count,
//            busy, done, key, key_valid
interface ropuf_controller_if #(
  parameter int N_BITS = 64,
  parameter int SEL_W  = 6
);
  import ropuf_pkg::*;

  logic              start;
  logic              abort;
  logic              cmp_bit;
  logic [SEL_W-1:0]  pair_sel;
  logic              ro_en;
  logic              cnt_clr;
  logic [7:0]        count;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] key;
  logic              key_valid;

  modport master (
    output start, abort, cmp_bit,
    input  pair_sel, ro_en, cnt_clr, count, busy, done, key, key_valid
  );

  modport slave (
    input  start, abort, cmp_bit,
    output pair_sel, ro_en, cnt_clr, count, busy, done, key, key_valid
  );

endinterface

// File: rtl/ropuf_vote.sv
// Per-pair majority voter: counts comparator ones over REPEAT evaluations
// and reports whether they form a strict majority.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of the ones count (has priority)
//   add        : accumulate bit_in this cycle
//   bit_in     : comparator bit
//   ones       : current ones count
//   maj        : ones > REPEAT/2
module ropuf_vote
  import ropuf_pkg::*;
#(
  parameter int REPEAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic       bit_in,
  output logic [2:0] ones,
  output logic       maj
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= 3'd0;
    end else if (clr) begin
      ones <= 3'd0;
    end else if (add) begin
      ones <= ones + {2'b00, bit_in};
    end
  end

  assign maj = (ones > 3'(REPEAT / 2));

endmodule

// File: rtl/ropuf_controller.sv
// Ring-oscillator PUF response sequencer. Walks every RO pair, runs REPEAT
// fixed-length evaluations per pair, majority-votes the comparator bit and
// assembles the N_BITS response word.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of ropuf_controller_if (start/abort/cmp_bit in;
//                pair_sel/ro_en/cnt_clr/count/busy/done/key/key_valid out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; oscillators off, count 0
// S_CLEAR | one cycle clearing both RO counters
// S_RUN   | oscillators enabled, count 0..244
// S_HOLD  | oscillators frozen, count 245..250, cmp_bit taken at 248
// S_NEXT  | one cycle writing the voted bit for the current pair
// S_DONE  | one-cycle done pulse, key_valid raised
module ropuf_controller
  import ropuf_pkg::*;
#(
  parameter int N_BITS = 64,
  parameter int SEL_W  = 6,
  parameter int REPEAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ropuf_controller_if.slave   bus
);

  if ((REPEAT % 2) == 0 || REPEAT < 1 || REPEAT > 7) begin : g_bad_repeat
    $error("ropuf_controller: REPEAT must be odd and within 1..7");
  end
  if (SEL_W < $clog2(N_BITS)) begin : g_bad_sel_w
    $error("ropuf_controller: SEL_W too narrow for N_BITS");
  end

  localparam logic [SEL_W-1:0] LAST_PAIR = SEL_W'(N_BITS - 1);
  localparam logic [2:0]       LAST_REP  = 3'(REPEAT - 1);

  state_t            state;
  logic [SEL_W-1:0]  pair_idx;
  logic [2:0]        rep_idx;
  logic [7:0]        count_q;
  logic              ro_en_q;
  logic              cnt_clr_q;
  logic              busy_q;
  logic              done_q;
  logic [N_BITS-1:0] key_q;
  logic              key_valid_q;

  logic              vote_clr;
  logic              vote_add;
  logic [2:0]        ones;
  logic              maj;

  // Ones are cleared on every accepted start and after each pair's bit is
  // written, so each pair starts its vote from zero.
  assign vote_clr = (state == S_IDLE && bus.start && !bus.abort) || (state == S_NEXT);
  assign vote_add = (state == S_HOLD) && (count_q == SAMPLE_AT) && !bus.abort;

  ropuf_vote #(
    .REPEAT (REPEAT)
  ) u_vote (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (vote_clr),
    .add    (vote_add),
    .bit_in (bus.cmp_bit),
    .ones   (ones),
    .maj    (maj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pair_idx    <= '0;
      rep_idx     <= 3'd0;
      count_q     <= 8'd0;
      ro_en_q     <= 1'b0;
      cnt_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cnt_clr_q <= 1'b0;
      if (bus.abort) begin
        state       <= S_IDLE;
        rep_idx     <= 3'd0;
        count_q     <= 8'd0;
        ro_en_q     <= 1'b0;
        busy_q      <= 1'b0;
        key_valid_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state       <= S_CLEAR;
              pair_idx    <= '0;
              rep_idx     <= 3'd0;
              key_q       <= '0;
              key_valid_q <= 1'b0;
              busy_q      <= 1'b1;
              cnt_clr_q   <= 1'b1;
              count_q     <= 8'd0;
            end
          end
          S_CLEAR: begin
            state   <= S_RUN;
            ro_en_q <= 1'b1;
            count_q <= 8'd0;
          end
          S_RUN: begin
            count_q <= count_q + 8'd1;
            if (count_q == RUN_END) begin
              state   <= S_HOLD;
              ro_en_q <= 1'b0;
            end
          end
          S_HOLD: begin
            if (count_q == WIN_HI) begin
              count_q <= 8'd0;
              if (rep_idx < LAST_REP) begin
                rep_idx   <= rep_idx + 3'd1;
                state     <= S_CLEAR;
                cnt_clr_q <= 1'b1;
              end else begin
                state <= S_NEXT;
              end
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
          S_NEXT: begin
            for (int i = 0; i < N_BITS; i++) begin
              if (pair_idx == SEL_W'(i)) key_q[i] <= maj;
            end
            rep_idx <= 3'd0;
            count_q <= 8'd0;
            if (pair_idx == LAST_PAIR) begin
              state       <= S_DONE;
              done_q      <= 1'b1;
              key_valid_q <= 1'b1;
            end else begin
              pair_idx  <= pair_idx + 1'b1;
              state     <= S_CLEAR;
              cnt_clr_q <= 1'b1;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pair_sel  = pair_idx;
  assign bus.ro_en     = ro_en_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_ropuf_controller.sv
// Directed bench for ropuf_controller. Instance a (N_BITS=2, REPEAT=1) covers
// single-vote timing; instance b (N_BITS=8, REPEAT=3) covers voting, abort,
// start-while-busy and asynchronous reset.
module tb_ropuf_controller;
  import ropuf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ropuf_controller_if #(.N_BITS(2), .SEL_W(1)) a_if ();
  ropuf_controller_if #(.N_BITS(8), .SEL_W(3)) b_if ();

  ropuf_controller #(.N_BITS(2), .SEL_W(1), .REPEAT(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  ropuf_controller #(.N_BITS(8), .SEL_W(3), .REPEAT(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  // Comparator models. a: pair 0 -> 1, pair 1 -> 0.
  // b: per-pair bit sequence over the three repeats (bit r = repeat r).
  // Votes: 1,0,1,0,1,0,1,0 -> key 8'h55.
  localparam logic [2:0] PAT_B [8] = '{3'b101, 3'b010, 3'b111, 3'b000,
                                       3'b011, 3'b100, 3'b110, 3'b001};
  logic [1:0] b_rep;
  logic [2:0] b_cur_pair;
  logic       b_have;
  logic [2:0] b_pat;

  assign a_if.cmp_bit = (a_if.pair_sel == 1'b0);

  always_comb begin
    b_pat = PAT_B[b_if.pair_sel];
    b_if.cmp_bit = b_pat[b_rep];
  end

  // Repeat tracker: each counter clear starts an evaluation; a new pair
  // (or a fresh run) restarts the repeat index.
  always @(posedge clk) begin
    if (!b_if.busy) begin
      b_have <= 1'b0;
      b_rep  <= 2'd0;
    end else if (b_if.cnt_clr) begin
      if (!b_have || b_if.pair_sel != b_cur_pair) begin
        b_rep      <= 2'd0;
        b_cur_pair <= b_if.pair_sel;
        b_have     <= 1'b1;
      end else begin
        b_rep <= b_rep + 2'd1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_start();
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
  endtask

  task automatic wait_b(input logic [2:0] p, input logic [7:0] c, output bit ok);
    int k = 0;
    while (!(b_if.pair_sel == p && b_if.count == c) && k < 8000) begin
      tick();
      k++;
    end
    ok = (b_if.pair_sel == p && b_if.count == c);
  endtask

  // Runs b from the cycle after the start edge until done (bounded).
  // n counts edges with the start-sampling edge as 1.
  task automatic b_run(input bit poke, output int n, output int bad_sel, output int max_cnt);
    logic [2:0] prev;
    bit poked;
    n = 1;
    bad_sel = 0;
    max_cnt = int'(b_if.count);
    prev = b_if.pair_sel;
    poked = 1'b0;
    while (!b_if.done && n < 7000) begin
      if (poke && !poked && b_if.pair_sel == 3'd3 && b_if.count == 8'd100) begin
        b_if.start = 1'b1;
        poked = 1'b1;
      end
      tick();
      b_if.start = 1'b0;
      n++;
      if (b_if.pair_sel != prev && !b_if.cnt_clr) bad_sel++;
      prev = b_if.pair_sel;
      if (int'(b_if.count) > max_cnt) max_cnt = int'(b_if.count);
    end
  endtask

  initial begin
    int n, run, runs, bad_run, max_cnt, ro_in_win, bad_sel;
    bit ok;

    rst_n = 1'b0;
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    b_if.start = 1'b0;
    b_if.abort = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk("rst_pair_sel", b_if.pair_sel, 0);
    chk("rst_count", b_if.count, 0);
    chk("rst_key", b_if.key, 0);
    chk("rst_busy", b_if.busy, 0);
    chk("rst_done", b_if.done, 0);
    chk("rst_key_valid", b_if.key_valid, 0);
    chk("rst_ro_en", b_if.ro_en, 0);
    chk("rst_cnt_clr", b_if.cnt_clr, 0);
    chk("rst_a_key", a_if.key, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_count", b_if.count, 0);
    chk("idle_busy", b_if.busy, 0);
    chk("idle_cnt_clr", b_if.cnt_clr, 0);

    // Single-vote timing on instance a
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    chk("a_clear_cnt_clr", a_if.cnt_clr, 1);
    chk("a_clear_busy", a_if.busy, 1);
    n = 1; run = 0; runs = 0; bad_run = 0; max_cnt = 0; ro_in_win = 0;
    while (!a_if.done && n < 2000) begin
      tick();
      n++;
      if (a_if.ro_en) run++;
      else if (run != 0) begin
        runs++;
        if (run != 245) bad_run++;
        run = 0;
      end
      if (int'(a_if.count) > max_cnt) max_cnt = int'(a_if.count);
      if (a_if.count >= WIN_LO && a_if.ro_en) ro_in_win++;
    end
    chk("a_done_cycle", n, 507);
    chk("a_key", a_if.key, 2'b01);
    chk("a_key_valid", a_if.key_valid, 1);
    chk("a_ro_runs", runs, 2);
    chk("a_ro_run_len", bad_run, 0);
    chk("a_count_peak", max_cnt, 250);
    chk("a_ro_off_in_window", ro_in_win, 0);
    tick();
    chk("a_after_done_pulse", a_if.done, 0);
    chk("a_after_busy", a_if.busy, 0);
    chk("a_after_key_valid", a_if.key_valid, 1);

    // Majority vote plus ignored start during pair 3 on instance b
    b_start();
    b_run(1'b1, n, bad_sel, max_cnt);
    chk("b_done_cycle", n, 6057);
    chk("b_key", b_if.key, 8'h55);
    chk("b_key_valid", b_if.key_valid, 1);
    chk("b_pair_sel_stable", bad_sel, 0);
    chk("b_count_peak", max_cnt, 250);
    repeat (3) tick();
    chk("b_idle_busy", b_if.busy, 0);
    chk("b_idle_key_hold", b_if.key, 8'h55);
    chk("b_idle_key_valid", b_if.key_valid, 1);

    // Abort while idle drops key_valid, keeps key
    b_if.abort = 1'b1;
    tick();
    b_if.abort = 1'b0;
    chk("b_idle_abort_kv", b_if.key_valid, 0);
    chk("b_idle_abort_key", b_if.key, 8'h55);

    // Abort at count 100 of pair 5
    b_start();
    chk("b_start_key_clr", b_if.key, 0);
    chk("b_start_busy", b_if.busy, 1);
    chk("b_start_pair", b_if.pair_sel, 0);
    wait_b(3'd5, 8'd100, ok);
    chk("b_wait_pair5", ok, 1);
    chk("b_pair5_ro_en", b_if.ro_en, 1);
    b_if.abort = 1'b1;
    tick();
    b_if.abort = 1'b0;
    chk("b_abort_busy", b_if.busy, 0);
    chk("b_abort_ro_en", b_if.ro_en, 0);
    chk("b_abort_count", b_if.count, 0);
    chk("b_abort_key_valid", b_if.key_valid, 0);
    chk("b_abort_key_partial", b_if.key, 8'h15);
    repeat (5) tick();
    chk("b_abort_stays_idle", b_if.count, 0);
    chk("b_abort_no_clear", b_if.cnt_clr, 0);

    // Fresh start after abort
    b_start();
    chk("b_restart_key_clr", b_if.key, 0);
    b_run(1'b0, n, bad_sel, max_cnt);
    chk("b_restart_done_cycle", n, 6057);
    chk("b_restart_key", b_if.key, 8'h55);
    tick();

    // Asynchronous reset during HOLD
    b_start();
    wait_b(3'd1, 8'd247, ok);
    chk("b_wait_hold", ok, 1);
    chk("b_hold_key_partial", b_if.key, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("b_async_count", b_if.count, 0);
    chk("b_async_busy", b_if.busy, 0);
    chk("b_async_key", b_if.key, 0);
    chk("b_async_pair_sel", b_if.pair_sel, 0);
    chk("b_async_ro_en", b_if.ro_en, 0);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("b_post_rst_count", b_if.count, 0);
    chk("b_post_rst_busy", b_if.busy, 0);
    chk("b_post_rst_key", b_if.key, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ropuf_controller.md
# ropuf_controller

Sequencer for the ring-oscillator PUF response path. For each RO pair it selects the pair through the pair mux and clears the pair's up/down counters. It then enables the oscillators for a fixed window, drives the 8-bit window count that gates the comparator, and samples the comparator bit. Optional odd-count majority voting is applied per pair, and the voted bits are assembled into an N_BITS response word for the key path, with a start/done handshake.

## Interface
- N_BITS, 64, response bits, one per RO pair, 2..256.
- SEL_W, 6, pair-select width, at least clog2(N_BITS).
- REPEAT, 3, evaluations per pair; must be odd, 1..7.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin response generation; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- cmp_bit  in  1  comparator output, valid while count is 245..250.
- pair_sel  out  SEL_W  index of the RO pair currently routed to the counters.
- ro_en  out  1  oscillator/counter enable.
- cnt_clr  out  1  synchronous clear of both 16-bit RO counters.
- count  out  8  window count to the comparator.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the response is complete.
- key  out  N_BITS  response; bit i is the voted bit of pair i.
- key_valid  out  1  high from done until the next accepted start, or until abort.

## Operation
- The machine has six states: IDLE, CLEAR, RUN, HOLD, NEXT, DONE.
- **IDLE**
  - busy=0, ro_en=0, cnt_clr=0, count=0.
  - When start=1 (and abort=0): go to CLEAR, clear pair_idx, rep_idx, ones and key; drop key_valid; raise busy.
- **CLEAR** (1 cycle)
  - cnt_clr=1, ro_en=0, count=0. Then go to RUN.
- **RUN**
  - ro_en=1, count increments by 1 each cycle starting from 0.
  - Leave for HOLD on the cycle where count=244, so count is 245 on entry to HOLD.
- **HOLD** (count 245..250)
  - ro_en=0, count keeps incrementing.
  - At count=248, add cmp_bit into ones (3-bit register).
  - At count=250:
    - if rep_idx<REPEAT-1: increment rep_idx, go to CLEAR;
    - otherwise go to NEXT.
- **NEXT** (1 cycle)
  - key[pair_idx] <= (ones > REPEAT/2). Clear ones and rep_idx; set count=0.
  - If pair_idx=N_BITS-1, go to DONE; otherwise increment pair_idx and go to CLEAR.
- **DONE** (1 cycle)
  - done=1, key_valid set, busy=0 on the next cycle. Go to IDLE.
- **pair_sel** equals pair_idx and is stable for the whole evaluation of a pair, including all repeats.
- **abort**
  - Takes precedence over start and over every transition.
  - Next state is IDLE with ro_en=0 and count=0. key_valid=0, and key keeps its partial content.
- **start while busy** is ignored.

## Timing
- Reset values: state=IDLE and every output 0 (pair_sel, count, key, busy, done, key_valid, ro_en, cnt_clr).
- Reset taking effect mid-run returns the block to IDLE immediately.
- One evaluation takes 252 cycles: CLEAR 1 + RUN 245 + HOLD 6.
- One pair takes REPEAT×252+1 cycles.
- The accepted start cycle is followed by CLEAR on the next edge. done is asserted N_BITS×(REPEAT×252+1)+1 cycles after start is sampled; with the defaults that is 48449 cycles.
- ro_en is high for exactly 245 consecutive cycles per evaluation. It is low while cmp_bit is sampled, so the counters are frozen at the sample point.
- The count sequence is 0..250 and never reaches 251..255. The comparator therefore never sees an out-of-window hold state.
- key bits change only in NEXT, and key is constant while key_valid=1.

## Structure
- Shared package ropuf_pkg holds:
  - the state enum;
  - the constants RUN_END=244, WIN_LO=245, SAMPLE_AT=248, WIN_HI=250, and CNT_W=16 (RO counter width, used by the comparator and counters).
- Sub-module ropuf_vote: ones accumulator plus majority decision, parameterised by REPEAT.
- Elaboration-time check: REPEAT is odd and SEL_W is at least clog2(N_BITS).

## Test plan
- **Reset and idle:** hold rst_n=0 for 3 cycles → all outputs 0. Release with start=0 for 10 cycles → still IDLE, count=0.
- **Single-pair timing:** N_BITS=2, REPEAT=1, cmp_bit model returns 1 for pair 0 and 0 for pair 1 → done exactly 507 cycles after start, key=2'b01, key_valid=1. ro_en high for 245-cycle runs, count peaks at 250.
- **Majority vote:** REPEAT=3, pair 0 cmp_bit sequence 1,0,1 → key[0]=1. Pair 1 sequence 0,1,0 → key[1]=0.
- **Abort:** assert abort at count=100 of pair 5 → next cycle IDLE, ro_en=0, key_valid=0. A fresh start then completes normally with key cleared first.
- **Start ignored while busy:** pulse start during RUN of pair 3 → no restart, done timing unchanged.
- **Async reset mid-HOLD:** drop rst_n at count=247 → outputs 0 without waiting for a clock edge, and no key bit is written.
